// File: rtl/dataslot_target_requester.sv
// Issues one dataslot read/write command to core_bridge_cmd and reports its completion.
// Optional watchdog timeout is compiled in when DATASLOT_REQ_TIMEOUT_EN is defined.
module dataslot_target_requester #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000
) (
    input  logic        clk_74a,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_id,
    input  logic [31:0] req_slotoffset,
    input  logic [31:0] req_bridgeaddr,
    input  logic [31:0] req_length,
    output logic        target_dataslot_read,
    output logic        target_dataslot_write,
    output logic [15:0] target_dataslot_id,
    output logic [31:0] target_dataslot_slotoffset,
    output logic [31:0] target_dataslot_bridgeaddr,
    output logic [31:0] target_dataslot_length,
    input  logic        target_dataslot_ack,
    input  logic        target_dataslot_done,
    input  logic [2:0]  target_dataslot_err,
    output logic        rsp_valid,
    output logic [2:0]  rsp_err,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [15:0] id_q, id_d;
    logic [31:0] slot_q, slot_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic [2:0]  rsp_err_q, rsp_err_d;
    logic        done_ok;

`ifdef DATASLOT_REQ_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        rsp_timeout_q, rsp_timeout_d;
`else
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            id_q      <= '0;
            slot_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rsp_err_q <= '0;
`ifdef DATASLOT_REQ_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            id_q      <= id_d;
            slot_q    <= slot_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rsp_err_q <= rsp_err_d;
`ifdef DATASLOT_REQ_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        id_d      = id_q;
        slot_d    = slot_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rsp_err_d = rsp_err_q;
`ifdef DATASLOT_REQ_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        // A done seen while ack is still high belongs to the previous command.
        done_ok   = (state_q == WAIT_DONE) && !target_dataslot_ack && target_dataslot_done;
        req_ready = (state_q == IDLE) && !target_dataslot_ack;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d = req_write;
                    id_d    = req_id;
                    slot_d  = req_slotoffset;
                    addr_d  = req_bridgeaddr;
                    len_d   = req_length;
                    state_d = ISSUE;
`ifdef DATASLOT_REQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ISSUE: begin
                if (target_dataslot_ack) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_ok) begin
                    state_d   = RESP;
                    rsp_err_d = target_dataslot_err;
`ifdef DATASLOT_REQ_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef DATASLOT_REQ_TIMEOUT_EN
        // Watchdog overrides the wait unless completion lands in the same cycle.
        if (state_q == ISSUE || state_q == WAIT_DONE) begin
            cnt_d = cnt_q + 32'd1;
            if (!done_ok && cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                state_d       = RESP;
                rsp_err_d     = 3'b000;
                rsp_timeout_d = 1'b1;
            end
        end
`endif
    end

    assign target_dataslot_read       = (state_q == ISSUE) && !write_q;
    assign target_dataslot_write      = (state_q == ISSUE) && write_q;
    assign target_dataslot_id         = id_q;
    assign target_dataslot_slotoffset = slot_q;
    assign target_dataslot_bridgeaddr = addr_q;
    assign target_dataslot_length     = len_q;
    assign rsp_valid                  = (state_q == RESP);
    assign rsp_err                    = rsp_err_q;
    assign busy                       = (state_q != IDLE);
`ifdef DATASLOT_REQ_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dataslot_target_requester.sv
// Directed bench for dataslot_target_requester with a hand-driven host (ack/done/err).
// Timeout behaviour checked for whichever DATASLOT_REQ_TIMEOUT_EN build is compiled.
module tb_dataslot_target_requester;

    logic        clk_74a = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_id;
    logic [31:0] req_slotoffset, req_bridgeaddr, req_length;
    logic        rd, wr;
    logic [15:0] t_id;
    logic [31:0] t_slot, t_addr, t_len;
    logic        ack, done;
    logic [2:0]  err;
    logic        rsp_valid;
    logic [2:0]  rsp_err;
    logic        rsp_timeout, busy;

    int checks = 0;
    int failures = 0;
    int rsp_count = 0;
    int both_count = 0;

    dataslot_target_requester #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk_74a(clk_74a), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_id(req_id), .req_slotoffset(req_slotoffset),
        .req_bridgeaddr(req_bridgeaddr), .req_length(req_length),
        .target_dataslot_read(rd), .target_dataslot_write(wr),
        .target_dataslot_id(t_id), .target_dataslot_slotoffset(t_slot),
        .target_dataslot_bridgeaddr(t_addr), .target_dataslot_length(t_len),
        .target_dataslot_ack(ack), .target_dataslot_done(done), .target_dataslot_err(err),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk_74a = ~clk_74a;

    always @(negedge clk_74a) begin
        if (rsp_valid) rsp_count++;
        if (rd && wr) both_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic run_cmd(input logic w, input logic [15:0] id, input logic [31:0] so,
                           input logic [31:0] ba, input logic [31:0] ln,
                           input int ack_dly, input int done_dly, input logic [2:0] e);
        int rc0;
        rc0 = rsp_count;
        $display("txn cmd write=%0d id=%0h len=%0h ack_dly=%0d done_dly=%0d err=%0d",
                 w, id, ln, ack_dly, done_dly, e);
        req_write = w; req_id = id; req_slotoffset = so; req_bridgeaddr = ba; req_length = ln;
        req_valid = 1'b1;
        check("ready_idle", req_ready, 1'b1);
        step();
        // Scramble the request bus; the captured copy must not follow it.
        req_valid = 1'b0; req_id = ~id; req_length = ~ln; req_write = ~w;
        check("issue_rd", rd, !w);
        check("issue_wr", wr, w);
        check("issue_busy", busy, 1'b1);
        check("issue_id", t_id, id);
        check("issue_slot", t_slot, so);
        check("issue_addr", t_addr, ba);
        check("issue_len", t_len, ln);
        repeat (ack_dly) begin
            step();
            check("strobe_hold", w ? wr : rd, 1'b1);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("drop_rd", rd, 1'b0);
        check("drop_wr", wr, 1'b0);
        check("wait_busy", busy, 1'b1);
        repeat (done_dly - 1) step();
        check("no_early_rsp", rsp_valid, 1'b0);
        done = 1'b1; err = e;
        step();
        done = 1'b0; err = 3'd0;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_err", rsp_err, e);
        check("rsp_timeout", rsp_timeout, 1'b0);
        step();
        check("rsp_pulse_end", rsp_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("rsp_err_hold", rsp_err, e);
        check("param_stable_id", t_id, id);
        check("param_stable_len", t_len, ln);
        check("rsp_once", rsp_count, rc0 + 1);
    endtask

    initial begin
        int rc;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_id = '0;
        req_slotoffset = '0; req_bridgeaddr = '0; req_length = '0;
        ack = 1'b0; done = 1'b0; err = 3'd0;

        $display("txn reset");
        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_rd", rd, 1'b0);
        check("rst_wr", wr, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 3'd0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_id", t_id, 16'h0);
        check("rst_len", t_len, 32'h0);
        reset = 1'b0;
        step();
        check("rst_ready", req_ready, 1'b1);

        run_cmd(1'b0, 16'h0002, 32'h0000_0100, 32'h0000_0000, 32'h0000_4000, 2, 10, 3'd0);
        run_cmd(1'b1, 16'h0003, 32'h0000_0010, 32'h8000_0000, 32'h0000_0200, 1, 3, 3'd2);
        check("never_both_strobes", both_count, 0);

        // Host still shows done from the prior command.
        $display("txn stale_done id=4");
        rc = rsp_count;
        done = 1'b1;
        req_write = 1'b0; req_id = 16'h0004; req_length = 32'h40; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("stale_issue_rd", rd, 1'b1);
        check("stale_no_rsp_issue", rsp_valid, 1'b0);
        ack = 1'b1;
        step();
        check("stale_drop_rd", rd, 1'b0);
        check("stale_no_rsp_ack1", rsp_valid, 1'b0);
        step();
        check("stale_no_rsp_ack2", rsp_valid, 1'b0);
        check("stale_busy", busy, 1'b1);
        ack = 1'b0;
        step();
        check("stale_rsp", rsp_valid, 1'b1);
        done = 1'b0;
        step();
        check("stale_idle", busy, 1'b0);
        check("stale_rsp_once", rsp_count, rc + 1);

        $display("txn backpressure id=5");
        ack = 1'b1;
        req_write = 1'b1; req_id = 16'h0005; req_length = 32'h55; req_valid = 1'b1;
        #1;
        check("bp_ready_low", req_ready, 1'b0);
        step();
        check("bp_not_busy", busy, 1'b0);
        check("bp_no_capture", t_id, 16'h0004);
        step();
        check("bp_no_capture2", t_len, 32'h40);
        ack = 1'b0;
        #1;
        check("bp_ready_high", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        check("bp_busy", busy, 1'b1);
        check("bp_id", t_id, 16'h0005);
        check("bp_wr", wr, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0; done = 1'b1; err = 3'd1;
        step();
        check("bp_rsp", rsp_valid, 1'b1);
        check("bp_rsp_err", rsp_err, 3'd1);
        done = 1'b0; err = 3'd0;
        step();

        $display("txn timeout id=6");
        req_write = 1'b0; req_id = 16'h0006; req_length = 32'h66; req_valid = 1'b1;
        step();
        req_valid = 1'b0; err = 3'd5;
        repeat (15) step();
        check("to_strobe_c15", rd, 1'b1);
        check("to_no_rsp_c15", rsp_valid, 1'b0);
        step();
`ifdef DATASLOT_REQ_TIMEOUT_EN
        check("to_rsp", rsp_valid, 1'b1);
        check("to_flag", rsp_timeout, 1'b1);
        check("to_err", rsp_err, 3'd0);
        check("to_rd_drop", rd, 1'b0);
        err = 3'd0;
        step();
        check("to_idle", busy, 1'b0);

        $display("txn timeout_vs_done id=7");
        req_id = 16'h0007; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (13) step();
        done = 1'b1; err = 3'd4;
        step();
        check("tie_rsp", rsp_valid, 1'b1);
        check("tie_flag", rsp_timeout, 1'b0);
        check("tie_err", rsp_err, 3'd4);
        done = 1'b0; err = 3'd0;
        step();
`else
        check("to_off_hold_rd", rd, 1'b1);
        check("to_off_no_rsp", rsp_valid, 1'b0);
        repeat (24) step();
        check("to_off_hold_rd_late", rd, 1'b1);
        check("to_off_busy", busy, 1'b1);
        err = 3'd0;
        reset = 1'b1;
        #1;
        check("rst_issue_rd", rd, 1'b0);
        step();
        reset = 1'b0;
        step();
`endif

        $display("txn reset_in_wait id=8");
        rc = rsp_count;
        req_write = 1'b1; req_id = 16'h0008; req_length = 32'h88; req_valid = 1'b1;
        step();
        req_valid = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0;
        check("rw_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rw_busy_drop", busy, 1'b0);
        check("rw_wr", wr, 1'b0);
        check("rw_rd", rd, 1'b0);
        check("rw_rsp_valid", rsp_valid, 1'b0);
        check("rw_id_clr", t_id, 16'h0);
        done = 1'b1;
        step(); step();
        reset = 1'b0; done = 1'b0;
        step();
        check("rw_no_rsp", rsp_count, rc);
        check("rw_idle", busy, 1'b0);
        run_cmd(1'b0, 16'h0009, 32'h0000_0020, 32'h1000_0000, 32'h0000_0800, 1, 1, 3'd0);
        check("final_never_both", both_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
